// File: rtl/lsu_pkg.sv
// Shared encodings for the load/store unit: RV32I load/store funct3 codes,
// FSM state encoding and access-size helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACC_LO = 2'd1,
    ST_ACC_HI = 2'd2,
    ST_DONE   = 2'd3
  } lsu_state_e;

  // Byte-lane mask of an access before shifting by the address offset.
  function automatic logic [3:0] size_mask(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: return 1'b1;
      F3_BU, F3_HU:     return !we;
      default:          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering: store data shifted into the low/high dmem
// words, and load data realigned from the two captured words and extended.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_lo_word,
  input  logic [31:0] i_hi_word,
  output logic [7:0]  o_lanes,
  output logic [31:0] o_wdata_lo,
  output logic [31:0] o_wdata_hi,
  output logic [31:0] o_rdata
);

  logic [5:0]  w_sh_hi;
  logic [31:0] w_rd;

  assign o_lanes    = {4'b0000, size_mask(i_funct3)} << i_off;
  assign o_wdata_lo = i_wdata << {i_off, 3'b000};
  // Bytes that spilled past the low word; off=0 shifts by 32 and yields 0.
  assign w_sh_hi    = 6'd32 - {1'b0, i_off, 3'b000};
  assign o_wdata_hi = i_wdata >> w_sh_hi;
  assign w_rd       = 32'({i_hi_word, i_lo_word} >> {i_off, 3'b000});

  always_comb begin
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_rd[7]}}, w_rd[7:0]};
      F3_H:    o_rdata = {{16{w_rd[15]}}, w_rd[15:0]};
      F3_BU:   o_rdata = {24'h0, w_rd[7:0]};
      F3_HU:   o_rdata = {16'h0, w_rd[15:0]};
      default: o_rdata = w_rd;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit FSM: captures one request, issues one or two word-aligned
// dmem accesses, and returns a single-cycle response.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES        = 1024,
  parameter bit          ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] addr,
  output logic        MemRead,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic [31:0] data_in
);

  lsu_state_e  r_state;
  logic        r_we;
  logic        r_err;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_lo_word;
  logic [31:0] r_hi_word;

  logic [2:0]  w_bytes;
  logic [32:0] w_end;
  logic        w_cross;
  logic        w_req_err;
  logic [31:0] w_word_addr;
  logic [7:0]  w_lanes;
  logic [31:0] w_wdata_lo;
  logic [31:0] w_wdata_hi;
  logic [31:0] w_rdata_ext;

  assign w_bytes   = size_bytes(req_funct3);
  assign w_end     = {1'b0, req_addr} + {30'b0, w_bytes};
  assign w_cross   = ({2'b00, req_addr[1:0]} + {1'b0, w_bytes}) > 4'd4;
  // 33-bit end address: an access near 2^32 is out of range instead of wrapping.
  assign w_req_err = !f3_legal(req_funct3, req_we)
                   || (w_end > 33'(MEM_BYTES))
                   || (!ALLOW_MISALIGNED && w_cross);

  assign req_ready   = (r_state == ST_IDLE);
  assign w_word_addr = {r_addr[31:2], 2'b00};

  lsu_lane_align u_align (
    .i_off      (r_addr[1:0]),
    .i_funct3   (r_funct3),
    .i_wdata    (r_wdata),
    .i_lo_word  (r_lo_word),
    .i_hi_word  (r_hi_word),
    .o_lanes    (w_lanes),
    .o_wdata_lo (w_wdata_lo),
    .o_wdata_hi (w_wdata_hi),
    .o_rdata    (w_rdata_ext)
  );

  // NOTE: state uses <= only, and reset is sampled on the clock edge, so the
  // captured request and load words clear together with the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_we      <= 1'b0;
      r_err     <= 1'b0;
      r_funct3  <= 3'b000;
      r_addr    <= 32'h0;
      r_wdata   <= 32'h0;
      r_lo_word <= 32'h0;
      r_hi_word <= 32'h0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_we      <= req_we;
            r_funct3  <= req_funct3;
            r_addr    <= req_addr;
            r_wdata   <= req_wdata;
            r_err     <= w_req_err;
            r_lo_word <= 32'h0;
            r_hi_word <= 32'h0;
            r_state   <= w_req_err ? ST_DONE : ST_ACC_LO;
          end
        end
        ST_ACC_LO: begin
          if (!r_we) r_lo_word <= data_in;
          r_state <= (|w_lanes[7:4]) ? ST_ACC_HI : ST_DONE;
        end
        ST_ACC_HI: begin
          if (!r_we) r_hi_word <= data_in;
          r_state <= ST_DONE;
        end
        ST_DONE:  r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: every output gets a default first so no latch is inferred. Strobes
  // are also gated by rst_n so a reset asserted mid-access blocks the pending write.
  always_comb begin
    addr       = 32'h0;
    MemRead    = 1'b0;
    mem_we     = 4'b0000;
    mem_wdata  = 32'h0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    case (r_state)
      ST_ACC_LO: begin
        addr      = w_word_addr;
        MemRead   = !r_we && rst_n;
        mem_we    = (r_we && rst_n) ? w_lanes[3:0] : 4'b0000;
        mem_wdata = r_we ? w_wdata_lo : 32'h0;
      end
      ST_ACC_HI: begin
        addr      = w_word_addr + 32'd4;
        MemRead   = !r_we && rst_n;
        mem_we    = (r_we && rst_n) ? w_lanes[7:4] : 4'b0000;
        mem_wdata = r_we ? w_wdata_hi : 32'h0;
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        resp_err   = r_err;
        resp_rdata = (r_we || r_err) ? 32'h0 : w_rdata_ext;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a byte-array dmem model, a response scoreboard
// and a per-request trace of dmem access cycles.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned cyc;
    string       tag;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        rd;
    logic [3:0]  we;
    logic [31:0] wdata;
  } act_t;

  logic        clk;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] addr;
  logic        MemRead;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata, data_in;

  logic        req_valid_b, req_ready_b, req_we_b;
  logic [2:0]  req_funct3_b;
  logic [31:0] req_addr_b, req_wdata_b;
  logic        resp_valid_b, resp_err_b;
  logic [31:0] resp_rdata_b, addr_b, mem_wdata_b, data_in_b;
  logic        MemRead_b;
  logic [3:0]  mem_we_b;

  logic [7:0]  mem [0:1023];
  logic        mem_clr;
  int unsigned cyc;
  int          n_checks;
  int          n_errors;
  exp_t        sb [$];
  act_t        act_q [$];

  lsu_ctrl #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .addr(addr), .MemRead(MemRead), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .data_in(data_in)
  );

  lsu_ctrl #(.MEM_BYTES(1024), .ALLOW_MISALIGNED(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_we(req_we_b),
    .req_funct3(req_funct3_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .resp_valid(resp_valid_b), .resp_rdata(resp_rdata_b), .resp_err(resp_err_b),
    .addr(addr_b), .MemRead(MemRead_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
    .data_in(data_in_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign data_in   = {mem[{addr[9:2], 2'd3}], mem[{addr[9:2], 2'd2}],
                      mem[{addr[9:2], 2'd1}], mem[{addr[9:2], 2'd0}]};
  assign data_in_b = 32'h0;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else begin
      for (int k = 0; k < 4; k++)
        if (mem_we[k]) mem[{addr[9:2], 2'(k)}] <= mem_wdata[8*k +: 8];
    end
  end

  function automatic logic [31:0] mem_word(input int a);
    return {mem[a+3], mem[a+2], mem[a+1], mem[a]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: pops an expectation on every response pulse and logs dmem cycles.
  always @(negedge clk) begin : monitor
    exp_t e;
    act_t a;
    if (rst_n) begin
      check("mem_excl", 32'(MemRead && (|mem_we)), 32'h0);
      if (MemRead || (|mem_we)) begin
        a.addr  = addr;
        a.rd    = MemRead;
        a.we    = mem_we;
        a.wdata = mem_wdata;
        act_q.push_back(a);
      end
      if (resp_valid) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_errors++;
          $error("FAIL unexpected_resp: observed resp_valid=1 expected no response");
        end else begin
          e = sb.pop_front();
          check({e.tag, ".rdata"}, resp_rdata, e.rdata);
          check({e.tag, ".err"}, 32'(resp_err), 32'(e.err));
          check({e.tag, ".lat"}, 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input string tag);
    exp_t e;
    @(negedge clk);
    check({tag, ".ready"}, 32'(req_ready), 32'h1);
    act_q.delete();
    e.rdata = exp_rd;
    e.err   = exp_err;
    e.cyc   = cyc + 32'(lat);
    e.tag   = tag;
    sb.push_back(e);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 8 && sb.size() != 0; i++) @(negedge clk);
    #1;
    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s.timeout: observed no response expected one within 8 cycles", tag);
      sb.delete();
    end
  endtask

  task automatic issue_b(input logic [2:0] f3, input logic [31:0] a,
                         input logic exp_err, input int lat, input string tag);
    bit seen;
    seen = 1'b0;
    @(negedge clk);
    req_valid_b  = 1'b1;
    req_we_b     = 1'b0;
    req_funct3_b = f3;
    req_addr_b   = a;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      req_valid_b = 1'b0;
      if (resp_valid_b) begin
        seen = 1'b1;
        check({tag, ".lat"}, 32'(k), 32'(lat));
        check({tag, ".err"}, 32'(resp_err_b), 32'(exp_err));
      end
    end
    if (!seen) begin
      n_checks++;
      n_errors++;
      $error("FAIL %s.timeout: observed no response expected one within 8 cycles", tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_errors = 0; cyc = 0;
    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0; req_addr = 32'h0; req_wdata = 32'h0;
    req_valid_b = 1'b0; req_we_b = 1'b0; req_funct3_b = 3'b0; req_addr_b = 32'h0;
    req_wdata_b = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst.ready", 32'(req_ready), 32'h1);
    check("rst.resp_valid", 32'(resp_valid), 32'h0);
    check("rst.addr", addr, 32'h0);
    check("rst.memread", 32'(MemRead), 32'h0);
    check("rst.mem_we", 32'(mem_we), 32'h0);
    check("rst.rdata", resp_rdata, 32'h0);
    mem_clr = 1'b0;
    rst_n   = 1'b1;

    issue(1'b1, F3_W, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, "sw_10");
    check("sw_10.nact", 32'(act_q.size()), 32'h1);
    check("sw_10.addr", act_q[0].addr, 32'h10);
    check("sw_10.we", 32'(act_q[0].we), 32'hF);
    check("sw_10.rd", 32'(act_q[0].rd), 32'h0);
    check("sw_10.mem", mem_word(32'h10), 32'hDEADBEEF);
    check("sw_10.byte0", 32'(mem[32'h10]), 32'hEF);

    issue(1'b0, F3_W, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 2, "lw_10");
    check("lw_10.rd", 32'(act_q[0].rd), 32'h1);

    issue(1'b1, F3_B, 32'h13, 32'h00000080, 32'h0, 1'b0, 2, "sb_13");
    check("sb_13.we", 32'(act_q[0].we), 32'h8);
    check("sb_13.wdata", act_q[0].wdata, 32'h80000000);
    issue(1'b0, F3_B,  32'h13, 32'h0, 32'hFFFFFF80, 1'b0, 2, "lb_13");
    issue(1'b0, F3_BU, 32'h13, 32'h0, 32'h00000080, 1'b0, 2, "lbu_13");
    issue(1'b0, F3_H,  32'h12, 32'h0, 32'hFFFF80AD, 1'b0, 2, "lh_12");
    issue(1'b0, F3_HU, 32'h12, 32'h0, 32'h000080AD, 1'b0, 2, "lhu_12");

    issue(1'b1, F3_W, 32'h0E, 32'h11223344, 32'h0, 1'b0, 3, "sw_0e");
    check("sw_0e.nact", 32'(act_q.size()), 32'h2);
    check("sw_0e.lo_addr", act_q[0].addr, 32'h0C);
    check("sw_0e.lo_we", 32'(act_q[0].we), 32'hC);
    check("sw_0e.lo_wdata", act_q[0].wdata, 32'h33440000);
    check("sw_0e.hi_addr", act_q[1].addr, 32'h10);
    check("sw_0e.hi_we", 32'(act_q[1].we), 32'h3);
    check("sw_0e.hi_wdata", act_q[1].wdata, 32'h00001122);
    issue(1'b0, F3_W, 32'h0E, 32'h0, 32'h11223344, 1'b0, 3, "lw_0e");
    issue(1'b0, F3_W, 32'h10, 32'h0, 32'h80AD1122, 1'b0, 2, "lw_10b");
    issue(1'b0, F3_H, 32'h13, 32'h0, 32'h00000080, 1'b0, 3, "lh_13x");

    issue(1'b1, F3_H, 32'h23, 32'h1234ABCD, 32'h0, 1'b0, 3, "sh_23x");
    check("sh_23x.hi_we", 32'(act_q[1].we), 32'h1);
    issue(1'b0, F3_HU, 32'h23, 32'h0, 32'h0000ABCD, 1'b0, 3, "lhu_23x");

    issue(1'b0, F3_H, 32'h3FF, 32'h0, 32'h0, 1'b1, 1, "lh_3ff");
    check("lh_3ff.nact", 32'(act_q.size()), 32'h0);
    issue(1'b0, F3_W, 32'h3FC, 32'h0, 32'h0, 1'b0, 2, "lw_3fc");
    issue(1'b0, F3_W, 32'h3FD, 32'h0, 32'h0, 1'b1, 1, "lw_3fd");
    check("lw_3fd.nact", 32'(act_q.size()), 32'h0);
    issue(1'b1, F3_B, 32'h3FF, 32'hFFFFFF5A, 32'h0, 1'b0, 2, "sb_3ff");
    issue(1'b0, F3_BU, 32'h3FF, 32'h0, 32'h0000005A, 1'b0, 2, "lbu_3ff");

    issue(1'b0, 3'b011, 32'h20, 32'h0, 32'h0, 1'b1, 1, "f3_011");
    check("f3_011.nact", 32'(act_q.size()), 32'h0);
    issue(1'b1, F3_BU, 32'h20, 32'h77, 32'h0, 1'b1, 1, "sbu_ill");
    check("sbu_ill.nact", 32'(act_q.size()), 32'h0);
    check("sbu_ill.mem", 32'(mem[32'h20]), 32'h0);

    // Reset during the high half of a crossing store.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_W;
    req_addr = 32'h2E; req_wdata = 32'hAABBCCDD;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid.hi_addr", addr, 32'h30);
    check("rst_mid.hi_we", 32'(mem_we), 32'h3);
    rst_n = 1'b0;
    #1;
    check("rst_mid.we_gated", 32'(mem_we), 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid.ready", 32'(req_ready), 32'h1);
    check("rst_mid.addr", addr, 32'h0);
    check("rst_mid.mem_we", 32'(mem_we), 32'h0);
    check("rst_mid.resp_valid", 32'(resp_valid), 32'h0);
    check("rst_mid.lo_mem", mem_word(32'h2C), 32'hCCDD0000);
    check("rst_mid.hi_mem", mem_word(32'h30), 32'h0);
    rst_n = 1'b1;
    issue(1'b0, F3_W, 32'h2E, 32'h0, 32'h0000CCDD, 1'b0, 3, "lw_2e");

    issue_b(F3_W, 32'h02, 1'b1, 1, "b_lw_02");
    issue_b(3'b011, 32'h08, 1'b1, 1, "b_f3_011");
    issue_b(F3_H, 32'h01, 1'b0, 2, "b_lh_01");
    issue_b(F3_W, 32'h04, 1'b0, 2, "b_lw_04");

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
